voice_mixer: RTL and testbench

Consumes the per-voice sample outputs and note_on vector of the synth stage and produces one mixed mono sample per audio tick. Snapshots all voices on a sample strobe, accumulates the active voices serially (one per clock), then scales and saturates to the DAC/I2S width. The output is offered on a valid/ready handshake to the downstream serializer.

---
 rtl/voice_mixer_if.sv | 28 ++
 rtl/voice_mixer.sv | 241 ++++++++++++++++++++++++
 tb/tb_voice_mixer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_mixer_if.sv
// voice_mixer_if: groups the sample-set input and the mixed-output handshake
// of the voice mixer. The master side is the synth stage plus downstream
// serializer; the slave side is the mixer itself.
interface voice_mixer_if #(
  parameter int AUDIO_WIDTH = 32,
  parameter int NUM_VOICES  = 8,
  parameter int OUT_WIDTH   = 24
) ();
  logic                              sample_valid;
  logic [NUM_VOICES*AUDIO_WIDTH-1:0] voices_in;
  logic [NUM_VOICES-1:0]             note_on;
  logic [OUT_WIDTH-1:0]              mix_out;
  logic                              mix_valid;
  logic                              mix_ready;
  logic                              mix_clip;
  logic                              overrun;
  logic                              ovr_clr;

  modport master (
    output sample_valid, voices_in, note_on, mix_ready, ovr_clr,
    input  mix_out, mix_valid, mix_clip, overrun
  );

  modport slave (
    input  sample_valid, voices_in, note_on, mix_ready, ovr_clr,
    output mix_out, mix_valid, mix_clip, overrun
  );
endinterface

// File: rtl/voice_mixer.sv
// voice_mixer: snapshots all voices on sample_valid, sums the enabled ones
// serially (one voice per clock), shifts and saturates the sum to OUT_WIDTH
// and offers the result on a valid/ready handshake.
// Optional feature macro: VOICE_MIXER_PEAK_EN adds a peak-level meter
// (peak_level output, peak_clr input) updated on every accepted mix.
// The scale step takes two clocks (shift, then saturate) so that mix_valid
// rises NUM_VOICES+2 edges after the strobe is sampled.
// Saturation bounds assume AUDIO_WIDTH + clog2(NUM_VOICES) >= OUT_WIDTH.
module voice_mixer #(
  parameter int AUDIO_WIDTH = 32,
  parameter int NUM_VOICES  = 8,
  parameter int OUT_WIDTH   = 24,
  parameter int MIX_SHIFT   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  voice_mixer_if.slave         bus
`ifdef VOICE_MIXER_PEAK_EN
  ,
  output logic [OUT_WIDTH-1:0] peak_level,
  input  logic                 peak_clr
`endif
);

  localparam int ACC_W = AUDIO_WIDTH + $clog2(NUM_VOICES);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MAX_CODE = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN_CODE = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                            state_r;
  state_t                            state_nx;
  logic [NUM_VOICES*AUDIO_WIDTH-1:0] voices_snap_r;
  logic [NUM_VOICES-1:0]             note_snap_r;
  logic signed [ACC_W-1:0]           acc_r;
  logic [IDX_W-1:0]                  idx_r;
  logic                              scale_ph_r;
  logic [OUT_WIDTH-1:0]              mix_out_r;
  logic                              mix_valid_r;
  logic                              mix_clip_r;
  logic                              overrun_r;

  logic                              take_snap_s;
  logic                              drop_s;
  logic                              handshake_s;
  logic                              accum_last_s;
  logic signed [AUDIO_WIDTH-1:0]     voice_sel_s;
  logic signed [ACC_W-1:0]           addend_s;
  logic signed [ACC_W-1:0]           shifted_s;
  logic [OUT_WIDTH-1:0]              sat_val_s;
  logic                              sat_clip_s;

  // Next-state logic and control strobes for the mix sequence.
  always_comb begin
    state_nx     = state_r;
    take_snap_s  = 1'b0;
    drop_s       = 1'b0;
    handshake_s  = 1'b0;
    accum_last_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.sample_valid) begin
          take_snap_s = 1'b1;
          state_nx    = ACCUM;
        end else begin
          state_nx    = IDLE;
        end
      end
      ACCUM: begin
        drop_s = bus.sample_valid;
        if (idx_r == LAST_IDX) begin
          accum_last_s = 1'b1;
          state_nx     = SCALE;
        end else begin
          state_nx     = ACCUM;
        end
      end
      SCALE: begin
        drop_s = bus.sample_valid;
        if (scale_ph_r) begin
          state_nx = HOLD;
        end else begin
          state_nx = SCALE;
        end
      end
      HOLD: begin
        if (bus.mix_ready) begin
          handshake_s = 1'b1;
          if (bus.sample_valid) begin
            take_snap_s = 1'b1;
            state_nx    = ACCUM;
          end else begin
            state_nx    = IDLE;
          end
        end else begin
          drop_s   = bus.sample_valid;
          state_nx = HOLD;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Datapath: select the current voice, gate it, shift and saturate the sum.
  always_comb begin
    voice_sel_s = voices_snap_r[int'(idx_r)*AUDIO_WIDTH +: AUDIO_WIDTH];
    if (note_snap_r[idx_r]) begin
      addend_s = ACC_W'(voice_sel_s);
    end else begin
      addend_s = {ACC_W{1'b0}};
    end
    shifted_s = acc_r >>> MIX_SHIFT;
    if (acc_r > SAT_MAX) begin
      sat_val_s  = OUT_MAX_CODE;
      sat_clip_s = 1'b1;
    end else if (acc_r < SAT_MIN) begin
      sat_val_s  = OUT_MIN_CODE;
      sat_clip_s = 1'b1;
    end else begin
      sat_val_s  = acc_r[OUT_WIDTH-1:0];
      sat_clip_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Snapshot, serial accumulation and in-place shift of the running sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      voices_snap_r <= {(NUM_VOICES*AUDIO_WIDTH){1'b0}};
      note_snap_r   <= {NUM_VOICES{1'b0}};
      acc_r         <= {ACC_W{1'b0}};
      idx_r         <= {IDX_W{1'b0}};
      scale_ph_r    <= 1'b0;
    end else begin
      if (take_snap_s) begin
        voices_snap_r <= bus.voices_in;
        note_snap_r   <= bus.note_on;
        acc_r         <= {ACC_W{1'b0}};
        idx_r         <= {IDX_W{1'b0}};
        scale_ph_r    <= 1'b0;
      end else if (state_r == ACCUM) begin
        acc_r      <= acc_r + addend_s;
        idx_r      <= accum_last_s ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
        scale_ph_r <= 1'b0;
      end else if (state_r == SCALE && !scale_ph_r) begin
        acc_r      <= shifted_s;
        scale_ph_r <= 1'b1;
      end else begin
        scale_ph_r <= 1'b0;
      end
    end
  end

  // Output register: load the saturated mix, hold it until the handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mix_out_r   <= {OUT_WIDTH{1'b0}};
      mix_clip_r  <= 1'b0;
      mix_valid_r <= 1'b0;
    end else if (state_r == SCALE && scale_ph_r) begin
      mix_out_r   <= sat_val_s;
      mix_clip_r  <= sat_clip_s;
      mix_valid_r <= 1'b1;
    end else if (handshake_s) begin
      mix_valid_r <= 1'b0;
    end else begin
      mix_valid_r <= mix_valid_r;
    end
  end

  // Sticky overrun flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_r <= 1'b0;
    end else if (drop_s) begin
      overrun_r <= 1'b1;
    end else if (bus.ovr_clr) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign bus.mix_out   = mix_out_r;
  assign bus.mix_valid = mix_valid_r;
  assign bus.mix_clip  = mix_clip_r;
  assign bus.overrun   = overrun_r;

`ifdef VOICE_MIXER_PEAK_EN
  logic [OUT_WIDTH-1:0] peak_r;
  logic [OUT_WIDTH-1:0] mag_s;

  // Magnitude of the current mix, with the most negative code clamped.
  always_comb begin
    if (mix_out_r == OUT_MIN_CODE) begin
      mag_s = OUT_MAX_CODE;
    end else if (mix_out_r[OUT_WIDTH-1]) begin
      mag_s = (~mix_out_r) + OUT_WIDTH'(1);
    end else begin
      mag_s = mix_out_r;
    end
  end

  // Peak meter: track the largest accepted magnitude; clear has priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak_r <= {OUT_WIDTH{1'b0}};
    end else if (peak_clr) begin
      peak_r <= {OUT_WIDTH{1'b0}};
    end else if (handshake_s && (mag_s > peak_r)) begin
      peak_r <= mag_s;
    end else begin
      peak_r <= peak_r;
    end
  end

  assign peak_level = peak_r;
`endif

endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: randomized and directed checks of voice_mixer against a
// plain-arithmetic reference mix (signed sum, floor shift, clamp).
module tb_voice_mixer;
  localparam int AW = 32;
  localparam int NV = 8;
  localparam int OW = 24;
  localparam int SH = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  voice_mixer_if #(.AUDIO_WIDTH(AW), .NUM_VOICES(NV), .OUT_WIDTH(OW)) bus ();

`ifdef VOICE_MIXER_PEAK_EN
  logic [OW-1:0] peak_level;
  logic          peak_clr;
`endif

  voice_mixer #(.AUDIO_WIDTH(AW), .NUM_VOICES(NV), .OUT_WIDTH(OW), .MIX_SHIFT(SH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef VOICE_MIXER_PEAK_EN
    ,
    .peak_level (peak_level),
    .peak_clr   (peak_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {clip, mix[OW-1:0]}.
  function automatic logic [OW:0] ref_mix(input logic [NV*AW-1:0] v, input logic [NV-1:0] n);
    longint s;
    longint lo;
    longint hi;
    logic [AW-1:0] w;
    s  = 0;
    hi = (longint'(1) <<< (OW-1)) - 1;
    lo = -(longint'(1) <<< (OW-1));
    for (int k = 0; k < NV; k++) begin
      w = v[k*AW +: AW];
      if (n[k]) s = s + longint'($signed(w));
    end
    s = s >>> SH;
    if (s > hi) return {1'b1, 1'b0, {(OW-1){1'b1}}};
    else if (s < lo) return {1'b1, 1'b1, {(OW-1){1'b0}}};
    else return {1'b0, s[OW-1:0]};
  endfunction

  function automatic logic [NV*AW-1:0] fill(input logic [AW-1:0] val);
    logic [NV*AW-1:0] r;
    for (int k = 0; k < NV; k++) r[k*AW +: AW] = val;
    return r;
  endfunction

  task automatic strobe(input logic [NV*AW-1:0] v, input logic [NV-1:0] n);
    @(negedge clk);
    bus.voices_in    = v;
    bus.note_on      = n;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bus.voices_in    = {(NV*AW){1'b1}};
    bus.note_on      = {NV{1'b1}};
  endtask

  // Counts negedges until mix_valid is seen; -1 on timeout.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.mix_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.mix_valid !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.mix_out !== 24'h000000) begin errors++; $display("FAIL reset_mix_out got %h want 000000", bus.mix_out); end
    checks++;
    if (bus.mix_valid !== 1'b0) begin errors++; $display("FAIL reset_mix_valid got %b want 0", bus.mix_valid); end
    checks++;
    if (bus.mix_clip !== 1'b0) begin errors++; $display("FAIL reset_mix_clip got %b want 0", bus.mix_clip); end
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
  endtask

  task automatic test_directed();
    logic [NV*AW-1:0] v[5];
    logic [NV-1:0]    n[5];
    logic [OW:0]      want[5];
    logic [NV*AW-1:0] t;
    int               cyc;
    v[0] = fill(32'h0100_0000); n[0] = 8'hFF; want[0] = {1'b0, 24'h080000};
    v[1] = fill(32'h7FFF_FFFF); n[1] = 8'hFF; want[1] = {1'b1, 24'h7FFFFF};
    v[2] = fill(32'h8000_0000); n[2] = 8'hFF; want[2] = {1'b1, 24'h800000};
    t = fill(32'h7FFF_FFFF); t[31:0] = 32'h0001_0000;
    v[3] = t; n[3] = 8'h01; want[3] = {1'b0, 24'h000100};
    t[31:0] = 32'hFFFF_FFFF;
    v[4] = t; n[4] = 8'h01; want[4] = {1'b0, 24'hFFFFFF};
    bus.mix_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      strobe(v[i], n[i]);
      wait_valid(cyc);
      checks++;
      if (cyc != 10) begin errors++; $display("FAIL dir%0d_latency got %0d want 10", i, cyc); end
      checks++;
      if ({bus.mix_clip, bus.mix_out} !== want[i]) begin
        errors++; $display("FAIL dir%0d_mix got clip=%b out=%h want clip=%b out=%h",
                           i, bus.mix_clip, bus.mix_out, want[i][OW], want[i][OW-1:0]);
      end
      @(negedge clk);
      checks++;
      if (bus.mix_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_valid_width got %b want 0", i, bus.mix_valid); end
    end
  endtask

  task automatic test_random();
    logic [NV*AW-1:0] v;
    logic [NV-1:0]    n;
    logic [OW:0]      want;
    logic [AW-1:0]    w;
    int               cyc;
    bus.mix_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < NV; k++) begin
        w = $urandom();
        w = AW'($signed(w) >>> $urandom_range(0, 10));
        v[k*AW +: AW] = w;
      end
      n = NV'($urandom());
      want = ref_mix(v, n);
      strobe(v, n);
      wait_valid(cyc);
      checks++;
      if (cyc != 10) begin errors++; $display("FAIL rnd%0d_latency got %0d want 10", i, cyc); end
      checks++;
      if ({bus.mix_clip, bus.mix_out} !== want) begin
        errors++; $display("FAIL rnd%0d_mix got clip=%b out=%h want clip=%b out=%h",
                           i, bus.mix_clip, bus.mix_out, want[OW], want[OW-1:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hold_overrun();
    logic [NV*AW-1:0] va;
    logic [OW:0]      want;
    int               cyc;
    int               bad;
    va = fill(32'h0000_4000);
    want = ref_mix(va, 8'h0F);
    bus.mix_ready = 1'b0;
    strobe(va, 8'h0F);
    wait_valid(cyc);
    checks++;
    if (cyc != 10) begin errors++; $display("FAIL hold_latency got %0d want 10", cyc); end
    strobe(fill(32'h0100_0000), 8'hFF);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({bus.mix_valid, bus.mix_clip, bus.mix_out} !== {1'b1, want}) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_stable got %0d unstable cycles want 0", bad); end
    checks++;
    if (bus.overrun !== 1'b1) begin errors++; $display("FAIL hold_overrun got %b want 1", bus.overrun); end
    bus.mix_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mix_valid !== 1'b0) begin errors++; $display("FAIL hold_release got %b want 0", bus.mix_valid); end
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus.mix_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL hold_dropped_mix got %0d valid cycles want 0", bad); end
    bus.ovr_clr = 1'b1;
    @(negedge clk);
    bus.ovr_clr = 1'b0;
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b want 0", bus.overrun); end
  endtask

  task automatic test_back_to_back();
    logic [NV*AW-1:0] vb;
    logic [OW:0]      want;
    int               cyc;
    vb = fill(32'hFFF0_0000);
    want = ref_mix(vb, 8'hA5);
    bus.mix_ready = 1'b0;
    strobe(fill(32'h0000_1000), 8'hFF);
    wait_valid(cyc);
    checks++;
    if (cyc != 10) begin errors++; $display("FAIL b2b_first_latency got %0d want 10", cyc); end
    @(negedge clk);
    bus.mix_ready    = 1'b1;
    bus.voices_in    = vb;
    bus.note_on      = 8'hA5;
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    bus.voices_in    = {(NV*AW){1'b0}};
    checks++;
    if (bus.mix_valid !== 1'b0) begin errors++; $display("FAIL b2b_handshake got %b want 0", bus.mix_valid); end
    wait_valid(cyc);
    checks++;
    if (cyc != 10) begin errors++; $display("FAIL b2b_latency got %0d want 10", cyc); end
    checks++;
    if ({bus.mix_clip, bus.mix_out} !== want) begin
      errors++; $display("FAIL b2b_mix got clip=%b out=%h want clip=%b out=%h",
                         bus.mix_clip, bus.mix_out, want[OW], want[OW-1:0]);
    end
    checks++;
    if (bus.overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", bus.overrun); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [NV*AW-1:0] vf;
    logic [OW:0]      want;
    int               cyc;
    int               bad;
    bus.mix_ready = 1'b1;
    strobe(fill(32'h0200_0000), 8'hFF);
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.overrun !== 1'b1) begin errors++; $display("FAIL mid_overrun_set got %b want 1", bus.overrun); end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.mix_out, bus.mix_valid, bus.mix_clip, bus.overrun} !== {24'h000000, 3'b000}) begin
      errors++; $display("FAIL mid_reset got out=%h v=%b c=%b o=%b want all 0",
                         bus.mix_out, bus.mix_valid, bus.mix_clip, bus.overrun);
    end
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus.mix_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mid_no_residue_valid got %0d want 0", bad); end
    vf = fill(32'h0000_0300);
    want = ref_mix(vf, 8'h03);
    strobe(vf, 8'h03);
    wait_valid(cyc);
    checks++;
    if (cyc != 10) begin errors++; $display("FAIL mid_fresh_latency got %0d want 10", cyc); end
    checks++;
    if ({bus.mix_clip, bus.mix_out} !== want) begin
      errors++; $display("FAIL mid_fresh_mix got clip=%b out=%h want clip=%b out=%h",
                         bus.mix_clip, bus.mix_out, want[OW], want[OW-1:0]);
    end
    @(negedge clk);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b0;
    bus.sample_valid = 1'b0;
    bus.voices_in    = {(NV*AW){1'b0}};
    bus.note_on      = {NV{1'b0}};
    bus.mix_ready    = 1'b0;
    bus.ovr_clr      = 1'b0;
`ifdef VOICE_MIXER_PEAK_EN
    peak_clr         = 1'b0;
`endif
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_directed();
    test_random();
    test_hold_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
